// File: rtl/sc_screen_pkg.sv
// rtl/sc_screen_pkg.sv - shared screen-state type, priority merge and default patterns
//
// Purpose: common definitions for sc_screen_arbiter and sc_row_scanner.
// The 2-bit screen encoding doubles as the request priority, so a larger
// code always outranks a smaller one. SCR_GAME also stands for "no pending request".
// Pattern rows are packed LSB-first: row r occupies bits [8r+7:8r].

package sc_screen_pkg;

   typedef enum logic [1:0] {
      SCR_GAME  = 2'b00,
      SCR_WIN   = 2'b01,
      SCR_LOSE  = 2'b10,
      SCR_CRASH = 2'b11
   } screen_t;

   localparam logic [63:0] SC_PATTERN_WIN   = 64'h00242424003C4200;
   localparam logic [63:0] SC_PATTERN_LOSE  = 64'h0024242400423C00;
   localparam logic [63:0] SC_PATTERN_CRASH = 64'h8142241818244281;

   // Keep whichever request has the higher priority.
   function automatic screen_t prio_merge(input screen_t a, input screen_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sc_row_scanner.sv
// rtl/sc_row_scanner.sv - row divider, row counter and frame-done pulse
//
// Purpose: steps the displayed row every SCAN_DIV clocks and flags the
// cycle in which the row wraps from 7 back to 0.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   row        - row currently driven (0..7)
//   frame_done - high for the single cycle whose closing edge takes row 7 -> 0

module sc_row_scanner #(
   parameter int SCAN_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   output logic [2:0] row,
   output logic       frame_done
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

   logic [DW-1:0] div;
   logic          tick;

   assign tick       = (div == DIV_LAST);
   assign frame_done = tick && (row == 3'd7);

   always_ff @(posedge clk) begin
      if (rst) begin
         div <= '0;
         row <= '0;
      end else if (tick) begin
         div <= '0;
         row <= row + 3'd1;
      end else begin
         div <= div + 1'b1;
      end
   end

endmodule

// File: rtl/sc_screen_arbiter.sv
// rtl/sc_screen_arbiter.sv - game/result screen arbiter with row scan
//
// Purpose: chooses between the live game playfield and fixed WIN/LOSE/CRASH
// result screens. Requests are latched between frames and screen changes
// happen only at the frame boundary so a frame is never torn.
// Optional feature macro: SC_SCREEN_BLINK_EN (result screens blank on odd frames).
// Ports:
//   SC_ScreenARB_CLOCK_50          - clock, rising edge
//   SC_ScreenARB_RESET_InHigh      - synchronous active-high reset
//   SC_ScreenARB_GameRow_InBUS     - game playfield row for the current RowSel
//   SC_ScreenARB_WinReq_InLow      - win request, active low
//   SC_ScreenARB_LoseReq_InLow     - lose request, active low
//   SC_ScreenARB_CrashReq_InLow    - crash request, active low
//   SC_ScreenARB_Clear_InLow       - abort result screen, active low
//   SC_ScreenARB_RowSel_OutBUS     - row currently driven
//   SC_ScreenARB_RowData_OutBUS    - column data for RowSel
//   SC_ScreenARB_Screen_OutBUS     - active screen code
//   SC_ScreenARB_Busy_OutLow       - low while a result screen is shown
//   SC_ScreenARB_FrameDone_OutHigh - one-cycle pulse on row 7 -> 0

module sc_screen_arbiter
   import sc_screen_pkg::*;
#(
   parameter int          SCAN_DIV      = 4,
   parameter int          HOLD_FRAMES   = 8,
   parameter logic [63:0] PATTERN_WIN   = SC_PATTERN_WIN,
   parameter logic [63:0] PATTERN_LOSE  = SC_PATTERN_LOSE,
   parameter logic [63:0] PATTERN_CRASH = SC_PATTERN_CRASH
) (
   input  logic       SC_ScreenARB_CLOCK_50,
   input  logic       SC_ScreenARB_RESET_InHigh,
   input  logic [7:0] SC_ScreenARB_GameRow_InBUS,
   input  logic       SC_ScreenARB_WinReq_InLow,
   input  logic       SC_ScreenARB_LoseReq_InLow,
   input  logic       SC_ScreenARB_CrashReq_InLow,
   input  logic       SC_ScreenARB_Clear_InLow,
   output logic [2:0] SC_ScreenARB_RowSel_OutBUS,
   output logic [7:0] SC_ScreenARB_RowData_OutBUS,
   output logic [1:0] SC_ScreenARB_Screen_OutBUS,
   output logic       SC_ScreenARB_Busy_OutLow,
   output logic       SC_ScreenARB_FrameDone_OutHigh
);

   localparam int HW = $clog2(HOLD_FRAMES + 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);

   logic          clk;
   logic          rst;
   logic [2:0]    row;
   logic          frame_done;

   screen_t       state, state_nxt;
   screen_t       pend, pend_nxt, pend_in, req_now;
   logic [HW-1:0] hold, hold_nxt;
   logic          clr_flag, clr_nxt, clr_in;
   logic [63:0]   pattern;
   logic [7:0]    pattern_row;

   assign clk = SC_ScreenARB_CLOCK_50;
   assign rst = SC_ScreenARB_RESET_InHigh;

   sc_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
      .clk        (clk),
      .rst        (rst),
      .row        (row),
      .frame_done (frame_done)
   );

   // Highest-priority request asserted this cycle.
   always_comb begin
      req_now = SCR_GAME;
      if (!SC_ScreenARB_CrashReq_InLow)
         req_now = SCR_CRASH;
      else if (!SC_ScreenARB_LoseReq_InLow)
         req_now = SCR_LOSE;
      else if (!SC_ScreenARB_WinReq_InLow)
         req_now = SCR_WIN;
   end

   // Clear overrides any same-cycle request; the frame-done decision sees
   // this cycle's request and clear as well as the latched ones.
   always_comb begin
      pend_in   = SC_ScreenARB_Clear_InLow ? prio_merge(pend, req_now) : SCR_GAME;
      clr_in    = clr_flag | ~SC_ScreenARB_Clear_InLow;
      state_nxt = state;
      hold_nxt  = hold;
      pend_nxt  = pend_in;
      clr_nxt   = clr_in;
      if (frame_done) begin
         // Every frame boundary consumes or discards whatever is pending.
         pend_nxt = SCR_GAME;
         clr_nxt  = 1'b0;
         if (clr_in) begin
            state_nxt = SCR_GAME;
            hold_nxt  = '0;
         end else if (state == SCR_GAME) begin
            if (pend_in != SCR_GAME) begin
               state_nxt = pend_in;
               hold_nxt  = HOLD_INIT;
            end
         end else if (pend_in > state) begin
            state_nxt = pend_in;
            hold_nxt  = HOLD_INIT;
         end else if (hold <= HW'(1)) begin
            state_nxt = SCR_GAME;
            hold_nxt  = '0;
         end else begin
            hold_nxt = hold - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= SCR_GAME;
         pend     <= SCR_GAME;
         hold     <= '0;
         clr_flag <= 1'b0;
      end else begin
         state    <= state_nxt;
         pend     <= pend_nxt;
         hold     <= hold_nxt;
         clr_flag <= clr_nxt;
      end
   end

   always_comb begin
      pattern = PATTERN_WIN;
      case (state)
         SCR_LOSE:  pattern = PATTERN_LOSE;
         SCR_CRASH: pattern = PATTERN_CRASH;
         default:   pattern = PATTERN_WIN;
      endcase
      pattern_row = pattern[{row, 3'b000} +: 8];
   end

`ifdef SC_SCREEN_BLINK_EN
   // Frame parity restarts at 0 whenever a new screen is entered, so the
   // first frame of every result screen is visible.
   logic parity;

   always_ff @(posedge clk) begin
      if (rst)
         parity <= 1'b0;
      else if (frame_done)
         parity <= (state_nxt != state) ? 1'b0 : ~parity;
   end

   assign SC_ScreenARB_RowData_OutBUS = (state == SCR_GAME) ? SC_ScreenARB_GameRow_InBUS :
                                        parity              ? 8'h00 : pattern_row;
`else
   assign SC_ScreenARB_RowData_OutBUS = (state == SCR_GAME) ? SC_ScreenARB_GameRow_InBUS
                                                            : pattern_row;
`endif

   assign SC_ScreenARB_RowSel_OutBUS     = row;
   assign SC_ScreenARB_Screen_OutBUS     = state;
   assign SC_ScreenARB_Busy_OutLow       = (state == SCR_GAME);
   assign SC_ScreenARB_FrameDone_OutHigh = frame_done;

endmodule

// File: doc/sc_screen_arbiter.md
SC_SCREEN_ARBITER -- requirements
Module: sc_screen_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- SCAN_DIV, 4: clock cycles per displayed row (>=1).
- HOLD_FRAMES, 8: frames a result screen is held before returning to game (>=1).
- PATTERN_WIN, 64'h00242424003C4200: win screen; row r = bits [8r+7:8r].
- PATTERN_LOSE, 64'h0024242400423C00: lose screen, same row packing.
- PATTERN_CRASH, 64'h8142241818244281: crash screen, same row packing.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- SC_ScreenARB_CLOCK_50, in, 1: single clock, rising edge.
- SC_ScreenARB_RESET_InHigh, in, 1: synchronous, active-high reset.
- SC_ScreenARB_GameRow_InBUS, in, 8: playfield row from game datapath for the current RowSel.
- SC_ScreenARB_WinReq_InLow, in, 1: win screen request, active low, level sampled each cycle.
- SC_ScreenARB_LoseReq_InLow, in, 1: lose screen request, active low.
- SC_ScreenARB_CrashReq_InLow, in, 1: crash screen request, active low.
- SC_ScreenARB_Clear_InLow, in, 1: abort result screen, return to game, active low.
- SC_ScreenARB_RowSel_OutBUS, out, 3: row currently driven.
- SC_ScreenARB_RowData_OutBUS, out, 8: column data for RowSel.
- SC_ScreenARB_Screen_OutBUS, out, 2: active screen: 00 GAME, 01 WIN, 10 LOSE, 11 CRASH.
- SC_ScreenARB_Busy_OutLow, out, 1: low while a result screen is active.
- SC_ScreenARB_FrameDone_OutHigh, out, 1: one-cycle pulse on row 7->0 wrap.

Function
REQ-003 A divider SHALL count 0..SCAN_DIV-1; on terminal count RowSel SHALL increment mod 8 (7 wraps to 0).
REQ-004 FrameDone SHALL be high for exactly the cycle in which RowSel changes 7->0.
REQ-005 RowData SHALL be combinational: GAME -> GameRow_InBUS; WIN/LOSE/CRASH -> the pattern row indexed by RowSel.
REQ-006 Request priority SHALL be CRASH > LOSE > WIN; every sampled request SHALL be latched into a 2-bit pending register, keeping only the highest-priority value.
REQ-007 FSM states SHALL be GAME, WIN, LOSE, CRASH; transitions SHALL occur only in the FrameDone cycle (no mid-frame tearing).
REQ-008 GAME: pending non-empty at FrameDone -> enter pending state, clear pending, load hold counter with HOLD_FRAMES.
REQ-009 Result state: hold counter SHALL decrement per FrameDone; on reaching 0 -> GAME.
REQ-010 Result state: pending of strictly higher priority at FrameDone SHALL preempt (enter it, reload hold); equal or lower pending SHALL be discarded.
REQ-011 Clear low SHALL flush pending and set a clear flag; at next FrameDone FSM -> GAME, flag cleared.
REQ-012 Clear and any request low in the same cycle: clear SHALL win; the request is dropped.
REQ-013 Busy SHALL be low iff state != GAME; Screen SHALL encode state directly.

Reset
REQ-014 Reset SHALL set: divider 0, RowSel 0, state GAME, Screen 00, pending empty, hold 0, clear flag 0, Busy 1, FrameDone 0.
REQ-015 Reset mid-frame or mid-hold SHALL abandon it; the first FrameDone after release SHALL occur 8*SCAN_DIV cycles later.

Configuration
REQ-016 With SC_SCREEN_BLINK_EN defined, RowData SHALL be forced to 8'h00 in result states during odd frames (frame-parity bit toggles each FrameDone, reset 0, cleared on state entry); without it, result screens SHALL be steady and no parity register SHALL exist.

Structure
REQ-017 Package sc_screen_pkg SHALL hold the screen-state typedef (2-bit encoding), priority-merge function and default pattern constants.
REQ-018 Sub-module sc_row_scanner SHALL contain divider, row counter and FrameDone generation; the arbiter FSM stays in sc_screen_arbiter.

Verification (SCAN_DIV=2, HOLD_FRAMES=3, 16-cycle frame)
REQ-019 Reset release, GameRow=8'hA5 -> RowSel steps every 2 cycles, RowData=A5, FrameDone at cycle 16, Screen=00, Busy=1.
REQ-020 WinReq low one cycle at cycle 3 -> Screen=01 at cycle 16, RowSel 1 gives 8'h42, Screen=00 after three more FrameDones (cycle 64).
REQ-021 WinReq during WIN hold, then CrashReq low -> WIN kept until next FrameDone, then CRASH with hold reloaded to 3; LoseReq during CRASH ignored.
REQ-022 Clear and CrashReq low same cycle in GAME -> no transition; Clear during LOSE -> GAME at next FrameDone.
REQ-023 Reset asserted at RowSel=5 in CRASH -> next cycle RowSel=0, Screen=00, Busy=1, FrameDone 0.
REQ-024 With SC_SCREEN_BLINK_EN, WIN held -> RowData nonzero on first result frame, 8'h00 on second, nonzero on third.
